// File: rtl/miner_pkg.sv
// Shared types and chunk layout for the miner datapath: header fields, FSM states,
// and the builder for the 512-bit second header chunk.
package miner_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [31:0] nbits;
    logic [31:0] ntime;
    logic [31:0] merkle_tail;
  } hdr_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD = 32'h0000_0280;

  // Word i of the chunk sits at bits [32i+31:32i]; w5..w14 are zero padding.
  function automatic logic [511:0] pack_chunk(input hdr_t hdr, input logic [31:0] nonce);
    logic [511:0] c;
    c          = '0;
    c[31:0]    = hdr.merkle_tail;
    c[63:32]   = hdr.ntime;
    c[95:64]   = hdr.nbits;
    c[127:96]  = nonce;
    c[159:128] = PAD_WORD;
    c[511:480] = LEN_WORD;
    return c;
  endfunction

endpackage

// File: rtl/nonce_sched.sv
// Nonce scheduler: issues one header chunk per nonce, en/Win registered one cycle after the decision.
// Stalls on issue_ready low or a full in-flight window; stops on first hit, range end or abort.
module nonce_sched
  import miner_pkg::*;
#(
  parameter int DELAY        = 48,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  merkle_tail,
  input  logic [31:0]  ntime,
  input  logic [31:0]  nbits,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  input  logic         issue_ready,
  output logic         en,
  output logic [511:0] Win,
  input  logic         res_valid,
  input  logic         res_hit,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce
);

  // Counter covers the larger of the window and the nominal pipeline depth.
  localparam int DEPTH = (MAX_INFLIGHT > DELAY) ? MAX_INFLIGHT : DELAY;
  localparam int IW    = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LIMIT = IW'(MAX_INFLIGHT);

  state_t        state;
  hdr_t          hdr_q;
  logic [31:0]   nonce_q;
  logic [31:0]   res_nonce_q;
  logic [32:0]   remaining;
  logic [IW-1:0] inflight;

  logic active;
  logic res_acc;
  logic first_hit;
  logic do_issue;

  always_comb begin
    active    = (state == ISSUE) || (state == DRAIN);
    res_acc   = active && res_valid && (inflight != '0);
    first_hit = res_acc && res_hit && !found;
    // A first hit on this edge already suppresses the issue decided on the same edge.
    do_issue  = (state == ISSUE) && (remaining != '0) && issue_ready &&
                (inflight < LIMIT) && !first_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      res_nonce_q <= '0;
      remaining   <= '0;
      inflight    <= '0;
      en          <= 1'b0;
      Win         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      en   <= do_issue;
      done <= 1'b0;

      if (do_issue) begin
        Win       <= pack_chunk(hdr_q, nonce_q);
        nonce_q   <= nonce_q + 32'd1;
        remaining <= remaining - 33'd1;
      end

      if (do_issue && !res_acc)
        inflight <= inflight + IW'(1);
      else if (!do_issue && res_acc)
        inflight <= inflight - IW'(1);

      if (res_acc)
        res_nonce_q <= res_nonce_q + 32'd1;

      if (first_hit) begin
        found       <= 1'b1;
        found_nonce <= res_nonce_q;
      end

      case (state)
        IDLE: begin
          if (start) begin
            hdr_q       <= '{nbits: nbits, ntime: ntime, merkle_tail: merkle_tail};
            nonce_q     <= nonce_start;
            res_nonce_q <= nonce_start;
            remaining   <= {1'b0, nonce_end - nonce_start} + 33'd1;
            inflight    <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if ((do_issue && remaining == 33'd1) || abort || first_hit)
            state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sched.sv
// Bench for nonce_sched: directed jobs plus random ones, checked against an in-order pipeline model
// and job-level expectations derived from the nonce range, hit nonce and stop rules.
module tb_nonce_sched;

  localparam int DELAY = 2;
  localparam int MAXI  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, abort, issue_ready, res_valid, res_hit;
  logic [31:0]  merkle_tail, ntime, nbits, nonce_start, nonce_end;
  logic         en, busy, done, found;
  logic [511:0] Win;
  logic [31:0]  found_nonce;

  always #5 clk = ~clk;

  nonce_sched #(.DELAY(DELAY), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .start(start),
    .merkle_tail(merkle_tail), .ntime(ntime), .nbits(nbits),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .abort(abort), .issue_ready(issue_ready), .en(en), .Win(Win),
    .res_valid(res_valid), .res_hit(res_hit), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce)
  );

  int checks = 0;
  int errors = 0;

  // Current job as seen by the reference model
  logic [31:0] j_mt, j_nt, j_nb, exp_nonce, hit_nonce;
  bit hit_en, hold_res, stray;

  // Per-job observations
  int cyc = 0, start_cyc, first_en_cyc;
  int en_cnt, res_cnt, done_cnt, done_cyc, last_res_cyc, max_out;
  int n_bad_rdy, n_after_stop, n_bad_win;
  bit prev_rdy, stopped, abort_pend;
  logic [511:0] last_win;

  typedef struct packed {
    logic [31:0] nonce;
    int          due;
  } pend_t;
  pend_t pq[$];

  function automatic logic [511:0] chunk(input logic [31:0] nonce);
    logic [31:0]  w [16];
    logic [511:0] c;
    for (int i = 0; i < 16; i++) w[i] = 32'h0;
    w[0] = j_mt; w[1] = j_nt; w[2] = j_nb; w[3] = nonce;
    w[4] = 32'h8000_0000; w[15] = 32'h0000_0280;
    for (int i = 0; i < 16; i++) c[32*i +: 32] = w[i];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pipeline model and protocol monitor: sample first, then drive results for the next edge.
  always @(negedge clk) begin
    pend_t p;
    cyc++;
    if (reset) begin
      pq.delete();
      res_valid = 1'b0;
      res_hit   = 1'b0;
      last_win  = '0;
      prev_rdy  = issue_ready;
    end else begin
      if (en === 1'b1) begin
        en_cnt++;
        if (en_cnt == 1) first_en_cyc = cyc;
        chk("chunk", Win, chunk(exp_nonce));
        if (!prev_rdy) n_bad_rdy++;
        if (stopped) n_after_stop++;
        p.nonce = exp_nonce;
        p.due   = cyc + DELAY;
        pq.push_back(p);
        exp_nonce = exp_nonce + 32'd1;
      end else if (Win !== last_win) begin
        n_bad_win++;
      end
      last_win = Win;
      if (pq.size() > max_out) max_out = pq.size();
      if (abort_pend) stopped = 1'b1;
      abort_pend = abort && busy;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_rdy = issue_ready;
      if (stray) begin
        res_valid = 1'b1;
        res_hit   = 1'b1;
        stray     = 1'b0;
      end else if (!hold_res && pq.size() > 0 && pq[0].due <= cyc) begin
        res_valid = 1'b1;
        res_hit   = hit_en && ((pq[0].nonce - hit_nonce) < 32'd3);
        if (res_hit) stopped = 1'b1;
        res_cnt++;
        last_res_cyc = cyc;
        void'(pq.pop_front());
      end else begin
        res_valid = 1'b0;
        res_hit   = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_job(input logic [31:0] s, input logic [31:0] e);
    j_mt = $urandom; j_nt = $urandom; j_nb = $urandom;
    merkle_tail = j_mt; ntime = j_nt; nbits = j_nb;
    nonce_start = s; nonce_end = e;
    exp_nonce = s;
    en_cnt = 0; res_cnt = 0; done_cnt = 0; max_out = 0;
    n_bad_rdy = 0; n_after_stop = 0; n_bad_win = 0;
    done_cyc = 0; last_res_cyc = 0; first_en_cyc = 0;
    stopped = 1'b0; abort_pend = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    merkle_tail = $urandom; ntime = $urandom; nbits = $urandom;
    nonce_start = $urandom; nonce_end = $urandom;
  endtask

  // rdy_mode: 0 hold high, 1 toggle, 2 random
  task automatic run_until_done(input string tag, input int budget, input int rdy_mode);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (rdy_mode == 1) issue_ready = ~issue_ready;
      else if (rdy_mode == 2) issue_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk({tag, "/done_seen"}, done_cnt != 0, 1'b1);
    issue_ready = 1'b1;
    repeat (3) tick();
  endtask

  // exp_cnt < 0 means the issue count is bounded by the caller instead
  task automatic job_checks(input string tag, input int exp_cnt, input bit exp_found,
                            input logic [31:0] exp_fn);
    if (exp_cnt >= 0) chk({tag, "/issues"}, en_cnt, exp_cnt);
    chk({tag, "/results_eq_issues"}, res_cnt, en_cnt);
    chk({tag, "/done_after_last_result"}, done_cyc - last_res_cyc, 2);
    chk({tag, "/done_pulses"}, done_cnt, 1);
    chk({tag, "/found"}, found, exp_found);
    if (exp_found) chk({tag, "/found_nonce"}, found_nonce, exp_fn);
    chk({tag, "/no_issue_without_ready"}, n_bad_rdy, 0);
    chk({tag, "/no_issue_after_stop"}, n_after_stop, 0);
    chk({tag, "/win_stable_without_en"}, n_bad_win, 0);
    chk({tag, "/window_bound"}, max_out <= MAXI, 1'b1);
    chk({tag, "/busy_after_done"}, busy, 1'b0);
  endtask

  initial begin
    int n, len, off;
    logic [31:0] s;

    reset = 1'b1; start = 1'b0; abort = 1'b0; issue_ready = 1'b0;
    merkle_tail = '0; ntime = '0; nbits = '0; nonce_start = '0; nonce_end = '0;
    hit_en = 1'b0; hit_nonce = '0; hold_res = 1'b0; stray = 1'b0;
    res_valid = 1'b0; res_hit = 1'b0;
    repeat (3) tick();
    chk("reset/en", en, 1'b0);
    chk("reset/busy", busy, 1'b0);
    chk("reset/done", done, 1'b0);
    chk("reset/found", found, 1'b0);
    chk("reset/found_nonce", found_nonce, 32'h0);
    chk("reset/win", Win, 512'h0);
    reset = 1'b0;
    tick();

    // abort while idle does nothing
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (2) tick();
    chk("idle_abort/busy", busy, 1'b0);
    chk("idle_abort/en", en, 1'b0);

    // single nonce
    issue_ready = 1'b1;
    begin_job(32'h0, 32'h0);
    run_until_done("single", 60, 0);
    chk("single/first_en_latency", first_en_cyc - start_cyc, 2);
    job_checks("single", 1, 1'b0, 32'h0);

    // hit on the third result; later hits must not move found_nonce
    hit_en = 1'b1; hit_nonce = 32'h12;
    begin_job(32'h10, 32'h17);
    run_until_done("hit", 100, 0);
    chk("hit/issue_bound", (en_cnt >= 3) && (en_cnt <= 8), 1'b1);
    job_checks("hit", -1, 1'b1, 32'h12);
    hit_en = 1'b0;

    // wrap through all-ones
    begin_job(32'hFFFF_FFFE, 32'h1);
    run_until_done("wrap", 200, 2);
    job_checks("wrap", 4, 1'b0, 32'h0);

    // back-pressure with results withheld; mid-job start must be ignored
    hold_res = 1'b1;
    issue_ready = 1'b1;
    begin_job(32'h100, 32'h109);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) begin
        nonce_start = 32'hDEAD_0000; nonce_end = 32'hDEAD_0003; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      issue_ready = ~issue_ready;
      tick();
    end
    start = 1'b0;
    chk("bp/stalled_issues", en_cnt, MAXI);
    chk("bp/max_outstanding", max_out, MAXI);
    hold_res = 1'b0;
    run_until_done("bp", 200, 1);
    job_checks("bp", 10, 1'b0, 32'h0);

    // abort after five issues
    begin_job(32'h200, 32'h2FF);
    n = 0;
    while (en_cnt < 5 && n < 50) begin tick(); n++; end
    abort = 1'b1; tick(); abort = 1'b0;
    run_until_done("abort", 100, 0);
    chk("abort/issue_bound", (en_cnt >= 5) && (en_cnt <= 7), 1'b1);
    job_checks("abort", -1, 1'b0, 32'h0);

    // reset while draining, then a stray result, then a fresh job
    hold_res = 1'b1;
    begin_job(32'h300, 32'h302);
    repeat (8) tick();
    chk("rst_drain/busy_before", busy, 1'b1);
    chk("rst_drain/issued", en_cnt, 3);
    reset = 1'b1;
    #1;
    chk("rst_drain/en", en, 1'b0);
    chk("rst_drain/busy", busy, 1'b0);
    chk("rst_drain/win", Win, 512'h0);
    tick();
    reset = 1'b0;
    hold_res = 1'b0;
    done_cnt = 0;
    stray = 1'b1;
    repeat (4) tick();
    chk("stray/found", found, 1'b0);
    chk("stray/busy", busy, 1'b0);
    chk("stray/no_done", done_cnt, 0);
    begin_job(32'h400, 32'h405);
    run_until_done("after_reset", 100, 0);
    job_checks("after_reset", 6, 1'b0, 32'h0);

    // random jobs, some wrapping, some with a hit, random readiness
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 12));
      s   = (k % 2 == 0) ? (32'hFFFF_FFF8 + $urandom_range(0, 10)) : $urandom;
      off = int'($urandom_range(0, len - 1));
      hit_en    = 1'($urandom_range(0, 1));
      hit_nonce = s + off;
      begin_job(s, s + len - 1);
      issue_ready = 1'($urandom_range(0, 1));
      tick();
      nonce_start = $urandom; start = 1'b1; tick(); start = 1'b0;
      run_until_done("rand", 300, 2);
      if (hit_en) begin
        chk("rand/hit_issue_bound", (en_cnt >= off + 1) && (en_cnt <= len), 1'b1);
        job_checks("rand_hit", -1, 1'b1, hit_nonce);
      end else begin
        job_checks("rand_nohit", len, 1'b0, 32'h0);
      end
      repeat (2) tick();
      chk("rand/found_holds", found, hit_en);
    end
    hit_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
